// File: rtl/soc_ctrl_master_if.sv
// Bus bundle between the sleep-epoch controller and its environment
// (epoch requester, ADC, CIM engine). The controller takes the master view.
interface soc_ctrl_master_if;
  logic               epoch_req;
  logic               adc_valid;
  logic signed [15:0] adc_data;
  logic               new_sleep_epoch;
  logic               start_eeg_load;
  logic               new_eeg_data;
  logic signed [15:0] eeg;
  logic               inference_complete;
  logic               busy;
  logic               epoch_done;
  logic               overrun;
  logic               timeout;

  modport master (
    input  epoch_req, adc_valid, adc_data, inference_complete,
    output new_sleep_epoch, start_eeg_load, new_eeg_data, eeg,
           busy, epoch_done, overrun, timeout
  );

  modport slave (
    output epoch_req, adc_valid, adc_data, inference_complete,
    input  new_sleep_epoch, start_eeg_load, new_eeg_data, eeg,
           busy, epoch_done, overrun, timeout
  );
endinterface

// File: rtl/soc_ctrl_master.sv
// Sleep-epoch controller: buffers ADC samples in a small FIFO and streams
// NUM_SAMPLES of them to the CIM engine, spaced at least SAMPLE_GAP cycles,
// then waits for inference completion.
// Optional feature macro: SOC_CTRL_WATCHDOG_EN (inference watchdog).
module soc_ctrl_master #(
  parameter int unsigned NUM_SAMPLES    = 3000,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned SAMPLE_GAP     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1 << 20
) (
  input logic                clk,
  input logic                soc_ctrl_rst_n,
  soc_ctrl_master_if.master  bus
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SmpW = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
  localparam int unsigned GapW = (SAMPLE_GAP > 1) ? $clog2(SAMPLE_GAP) : 1;

  typedef enum logic [2:0] {StIdle, StEpoch, StStart, StLoad, StWaitInf} state_e;

  state_e             state_q, state_d;
  logic signed [15:0] mem [FIFO_DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    fill_q, fill_d;
  logic [SmpW-1:0]    smp_q, smp_d;
  logic [GapW-1:0]    gap_q, gap_d;
  logic signed [15:0] eeg_q, eeg_d;
  logic               overrun_q, overrun_d;
  logic               accept, fifo_full, pop, push_req, push, wd_expire, done;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign accept    = (state_q == StIdle) && bus.epoch_req;
  assign fifo_full = (fill_q == CntW'(FIFO_DEPTH));
  // A sample is issued in the same cycle it is popped, so eeg bypasses the register.
  assign pop       = (state_q == StLoad) && (fill_q != '0) && (gap_q == '0);
  assign push_req  = bus.adc_valid &&
                     ((state_q == StEpoch) || (state_q == StStart) || (state_q == StLoad));
  assign push      = push_req && (!fifo_full || pop);

  // Next-state, FIFO bookkeeping and sample pacing.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fill_d    = fill_q;
    smp_d     = smp_q;
    gap_d     = gap_q;
    eeg_d     = eeg_q;
    overrun_d = overrun_q;
    done      = 1'b0;

    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   fill_d = fill_q + CntW'(1);
      2'b01:   fill_d = fill_q - CntW'(1);
      default: fill_d = fill_q;
    endcase
    if (push_req && fifo_full && !pop) overrun_d = 1'b1;

    if (pop) begin
      smp_d = smp_q + SmpW'(1);
      gap_d = GapW'(SAMPLE_GAP - 1);
      eeg_d = mem[rd_ptr_q];
    end else if (gap_q != '0) begin
      gap_d = gap_q - GapW'(1);
    end

    unique case (state_q)
      StIdle: begin
        if (bus.epoch_req) begin
          state_d   = StEpoch;
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          fill_d    = '0;
          smp_d     = '0;
          gap_d     = '0;
          overrun_d = 1'b0;
        end
      end
      StEpoch: state_d = StStart;
      StStart: state_d = StLoad;
      StLoad: begin
        if (pop && (smp_q == SmpW'(NUM_SAMPLES - 1))) state_d = StWaitInf;
      end
      StWaitInf: begin
        if (bus.inference_complete || wd_expire) begin
          state_d = StIdle;
          done    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge soc_ctrl_rst_n) begin
    if (!soc_ctrl_rst_n) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
      smp_q     <= '0;
      gap_q     <= '0;
      eeg_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
      smp_q     <= smp_d;
      gap_q     <= gap_d;
      eeg_q     <= eeg_d;
      overrun_q <= overrun_d;
    end
  end

  // FIFO storage; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.adc_data;
  end

`ifdef SOC_CTRL_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WdW-1:0] wd_q, wd_d;
  logic           timeout_q, timeout_d;

  assign wd_expire = (state_q == StWaitInf) && (wd_q == WdW'(TIMEOUT_CYCLES - 1));

  // Watchdog counts only while waiting for inference; timeout is sticky.
  always_comb begin
    wd_d      = (state_q == StWaitInf) ? wd_q + WdW'(1) : '0;
    timeout_d = timeout_q;
    if (wd_expire && !bus.inference_complete) timeout_d = 1'b1;
    if (accept) timeout_d = 1'b0;
  end

  // Watchdog registers.
  always_ff @(posedge clk or negedge soc_ctrl_rst_n) begin
    if (!soc_ctrl_rst_n) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign wd_expire          = 1'b0;
  assign bus.timeout        = 1'b0;
`endif

  assign bus.new_sleep_epoch = (state_q == StEpoch);
  assign bus.start_eeg_load  = (state_q == StStart);
  assign bus.new_eeg_data    = pop;
  assign bus.eeg             = pop ? mem[rd_ptr_q] : eeg_q;
  assign bus.busy            = (state_q != StIdle);
  assign bus.epoch_done      = done;
  assign bus.overrun         = overrun_q;

endmodule

// File: tb/tb_soc_ctrl_master.sv
// Directed bench for soc_ctrl_master. dut_a: 4 samples, gap 1, watchdog 16.
// dut_b: 4 samples, gap 8, used to fill the FIFO and provoke overrun.
module tb_soc_ctrl_master;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  soc_ctrl_master_if ifa ();
  soc_ctrl_master_if ifb ();

  soc_ctrl_master #(
    .NUM_SAMPLES(4), .FIFO_DEPTH(4), .SAMPLE_GAP(1), .TIMEOUT_CYCLES(16)
  ) dut_a (
    .clk(clk), .soc_ctrl_rst_n(rst_n), .bus(ifa)
  );

  soc_ctrl_master #(
    .NUM_SAMPLES(4), .FIFO_DEPTH(4), .SAMPLE_GAP(8), .TIMEOUT_CYCLES(16)
  ) dut_b (
    .clk(clk), .soc_ctrl_rst_n(rst_n), .bus(ifb)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ifa.epoch_req = 1'b0; ifa.adc_valid = 1'b0; ifa.adc_data = '0; ifa.inference_complete = 1'b0;
    ifb.epoch_req = 1'b0; ifb.adc_valid = 1'b0; ifb.adc_data = '0; ifb.inference_complete = 1'b0;
  endtask

  // Runs 24 cycles on dut_a from IDLE with per-cycle input masks.
  task automatic a_epoch(input logic [23:0] req_m, input logic [23:0] val_m,
                         input logic [23:0] ic_m, input logic [15:0] base,
                         output int np, output int nse_n, output int done_c,
                         output logic [15:0] pv[4], output logic [23:0] busy_h,
                         output logic to_last);
    int k;
    k = 0; np = 0; nse_n = 0; done_c = -1; busy_h = '0; to_last = 1'b0;
    for (int i = 0; i < 4; i++) pv[i] = '0;
    for (int c = 0; c < 24; c++) begin
      ifa.epoch_req          = req_m[c];
      ifa.adc_valid          = val_m[c];
      ifa.adc_data           = base + 16'(k);
      ifa.inference_complete = ic_m[c];
      if (val_m[c]) k++;
      @(negedge clk);
      busy_h[c] = ifa.busy;
      if (ifa.new_sleep_epoch) nse_n++;
      if (ifa.epoch_done && done_c < 0) done_c = c;
      if (ifa.new_eeg_data) begin
        if (np < 4) pv[np] = ifa.eeg;
        np++;
      end
      if (c == 23) to_last = ifa.timeout;
      next_cycle();
    end
    idle_inputs();
  endtask

  // Runs 36 cycles on dut_b from IDLE, recording pulses and the overrun flag.
  task automatic b_epoch(input logic [39:0] vmask, input logic [15:0] base,
                         output int np, output logic [15:0] pv[4], output int pc[4],
                         output logic [39:0] ovr_h);
    int k;
    k = 0; np = 0; ovr_h = '0;
    for (int i = 0; i < 4; i++) begin pv[i] = '0; pc[i] = -1; end
    for (int c = 0; c < 36; c++) begin
      ifb.epoch_req = (c == 0);
      ifb.adc_valid = vmask[c];
      ifb.adc_data  = base + 16'(k);
      if (vmask[c]) k++;
      @(negedge clk);
      ovr_h[c] = ifb.overrun;
      if (ifb.new_eeg_data) begin
        if (np < 4) begin pv[np] = ifb.eeg; pc[np] = c; end
        np++;
      end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    logic [6:0] ctl;
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    ctl = {ifa.busy, ifa.new_sleep_epoch, ifa.start_eeg_load, ifa.new_eeg_data,
           ifa.epoch_done, ifa.overrun, ifa.timeout};
    checks++; if (ctl !== 7'b0) begin errors++; $display("FAIL reset_a_ctl got %b exp 0", ctl); end
    checks++; if (ifa.eeg !== 16'h0) begin errors++; $display("FAIL reset_a_eeg got %h exp 0", ifa.eeg); end
    ctl = {ifb.busy, ifb.new_sleep_epoch, ifb.start_eeg_load, ifb.new_eeg_data,
           ifb.epoch_done, ifb.overrun, ifb.timeout};
    checks++; if (ctl !== 7'b0) begin errors++; $display("FAIL reset_b_ctl got %b exp 0", ctl); end
    ifa.epoch_req = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL reset_req_held got %b exp 0", ifa.busy); end
    @(posedge clk); #1;
    ifa.epoch_req = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [15:0] d [7];
    logic [20:0] got, exp;
    logic [15:0] exp_eeg;
    d[0] = 16'h8001; d[1] = 16'h7FFF; d[2] = 16'hFFFF; d[3] = 16'h0002;
    d[4] = 16'h5555; d[5] = 16'hAAAA; d[6] = 16'h1234;
    for (int c = 0; c < 10; c++) begin
      ifa.epoch_req          = (c == 0);
      ifa.adc_valid          = (c >= 2 && c <= 8);
      ifa.adc_data           = '0;
      if (c >= 2 && c <= 8) ifa.adc_data = d[c-2];
      ifa.inference_complete = (c == 8);
      exp_eeg = 16'h0;
      if (c >= 3 && c <= 6) exp_eeg = d[c-3];
      if (c >= 7) exp_eeg = d[3];
      @(negedge clk);
      got = {ifa.new_sleep_epoch, ifa.start_eeg_load, ifa.new_eeg_data, ifa.busy,
             ifa.epoch_done, ifa.eeg};
      exp = {c == 1, c == 2, (c >= 3 && c <= 6), (c >= 1 && c <= 8), c == 8, exp_eeg};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL basic cycle %0d: got %h exp %h", c, got, exp);
      end
      next_cycle();
    end
    idle_inputs();
    checks++; if (ifa.overrun !== 1'b0) begin errors++; $display("FAIL basic_no_overrun got %b exp 0", ifa.overrun); end
  endtask

  task automatic finish_b(input string tag);
    ifb.inference_complete = 1'b1;
    @(negedge clk);
    checks++;
    if ({ifb.epoch_done, ifb.busy} !== 2'b11) begin
      errors++; $display("FAIL %s_done got %b exp 11", tag, {ifb.epoch_done, ifb.busy});
    end
    next_cycle();
    ifb.inference_complete = 1'b0;
    @(negedge clk);
    checks++; if (ifb.busy !== 1'b0) begin errors++; $display("FAIL %s_idle got %b exp 0", tag, ifb.busy); end
    next_cycle();
  endtask

  task automatic test_overrun();
    int np;
    logic [15:0] pv[4];
    int pc[4];
    logic [39:0] oh;
    // Six samples at cycles 2..7: the sixth hits a full FIFO.
    b_epoch(40'h00_0000_00FC, 16'h0100, np, pv, pc, oh);
    checks++; if (np != 4) begin errors++; $display("FAIL ovr_count got %0d exp 4", np); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pv[i] !== 16'h0100 + 16'(i) || pc[i] != 3 + 8 * i) begin
        errors++;
        $display("FAIL ovr_pulse%0d got %h@%0d exp %h@%0d", i, pv[i], pc[i], 16'h0100 + 16'(i), 3 + 8 * i);
      end
    end
    checks++; if (oh[7] !== 1'b0) begin errors++; $display("FAIL ovr_before got %b exp 0", oh[7]); end
    checks++; if (oh[8] !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", oh[8]); end
    checks++; if (oh[35] !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b exp 1", oh[35]); end
    finish_b("ovr1");
    // Fill to full, then write in the same cycle as a pop at cycle 11.
    b_epoch(40'h00_0000_087C, 16'h0200, np, pv, pc, oh);
    checks++; if (oh[0] !== 1'b1) begin errors++; $display("FAIL ovr_held_at_req got %b exp 1", oh[0]); end
    checks++; if (oh[1] !== 1'b0) begin errors++; $display("FAIL ovr_cleared got %b exp 0", oh[1]); end
    checks++; if (oh[35] !== 1'b0) begin errors++; $display("FAIL full_rd_wr_ovr got %b exp 0", oh[35]); end
    checks++; if (np != 4) begin errors++; $display("FAIL ovr2_count got %0d exp 4", np); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pv[i] !== 16'h0200 + 16'(i) || pc[i] != 3 + 8 * i) begin
        errors++;
        $display("FAIL ovr2_pulse%0d got %h@%0d exp %h@%0d", i, pv[i], pc[i], 16'h0200 + 16'(i), 3 + 8 * i);
      end
    end
    finish_b("ovr2");
  endtask

  task automatic test_midload_reset();
    logic [6:0] ctl;
    int np, nse_n, done_c;
    logic [15:0] pv[4];
    logic [23:0] bh;
    logic tl;
    for (int c = 0; c < 5; c++) begin
      ifa.epoch_req = (c == 0);
      ifa.adc_valid = (c >= 2);
      ifa.adc_data  = 16'h0300 + 16'(c >= 2 ? c - 2 : 0);
      @(negedge clk);
      if (c >= 3) begin
        checks++;
        if ({ifa.new_eeg_data, ifa.eeg} !== {1'b1, 16'h0300 + 16'(c - 3)}) begin
          errors++;
          $display("FAIL mid_pulse%0d got %b/%h exp 1/%h", c, ifa.new_eeg_data, ifa.eeg, 16'h0300 + 16'(c - 3));
        end
      end
      if (c < 4) next_cycle();
    end
    #1;
    rst_n = 1'b0;
    idle_inputs();
    #1;
    ctl = {ifa.busy, ifa.new_sleep_epoch, ifa.start_eeg_load, ifa.new_eeg_data,
           ifa.epoch_done, ifa.overrun, ifa.timeout};
    checks++; if (ctl !== 7'b0) begin errors++; $display("FAIL mid_rst_ctl got %b exp 0", ctl); end
    checks++; if (ifa.eeg !== 16'h0) begin errors++; $display("FAIL mid_rst_eeg got %h exp 0", ifa.eeg); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    a_epoch(24'h1, 24'h3C, 24'h100, 16'h0A00, np, nse_n, done_c, pv, bh, tl);
    checks++; if (np != 4) begin errors++; $display("FAIL restart_count got %0d exp 4", np); end
    checks++; if (done_c != 8) begin errors++; $display("FAIL restart_done got %0d exp 8", done_c); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pv[i] !== 16'h0A00 + 16'(i)) begin
        errors++; $display("FAIL restart_val%0d got %h exp %h", i, pv[i], 16'h0A00 + 16'(i));
      end
    end
  endtask

  task automatic test_ignore();
    int np, nse_n, done_c;
    logic [15:0] pv[4];
    logic [23:0] bh;
    logic tl;
    // epoch_req and inference_complete both at cycle 4 while in LOAD.
    a_epoch(24'h11, 24'h1FC, 24'h210, 16'h0C00, np, nse_n, done_c, pv, bh, tl);
    checks++; if (np != 4) begin errors++; $display("FAIL ign_count got %0d exp 4", np); end
    checks++; if (nse_n != 1) begin errors++; $display("FAIL ign_epochs got %0d exp 1", nse_n); end
    checks++; if (done_c != 9) begin errors++; $display("FAIL ign_done got %0d exp 9", done_c); end
    checks++; if (bh[10] !== 1'b0) begin errors++; $display("FAIL ign_idle got %b exp 0", bh[10]); end
    checks++; if (pv[3] !== 16'h0C03) begin errors++; $display("FAIL ign_last got %h exp 0c03", pv[3]); end
  endtask

  task automatic test_watchdog();
    int np, nse_n, done_c;
    logic [15:0] pv[4];
    logic [23:0] bh;
    logic tl;
    a_epoch(24'h1, 24'h3C, 24'h0, 16'h0D00, np, nse_n, done_c, pv, bh, tl);
    checks++; if (np != 4) begin errors++; $display("FAIL wd_count got %0d exp 4", np); end
`ifdef SOC_CTRL_WATCHDOG_EN
    checks++; if (done_c != 22) begin errors++; $display("FAIL wd_done got %0d exp 22", done_c); end
    checks++; if (tl !== 1'b1) begin errors++; $display("FAIL wd_timeout got %b exp 1", tl); end
    checks++; if (bh[23:22] !== 2'b01) begin errors++; $display("FAIL wd_busy got %b exp 01", bh[23:22]); end
`else
    checks++; if (done_c != -1) begin errors++; $display("FAIL wd_done got %0d exp -1", done_c); end
    checks++; if (tl !== 1'b0) begin errors++; $display("FAIL wd_timeout got %b exp 0", tl); end
    checks++; if (bh[23] !== 1'b1) begin errors++; $display("FAIL wd_busy got %b exp 1", bh[23]); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_midload_reset();
    test_ignore();
    test_watchdog();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/soc_ctrl_master.md
SOC_CTRL_MASTER -- requirements
Module: soc_ctrl_master

Interface
REQ-001 Parameter NUM_SAMPLES, default 3000: EEG samples delivered per sleep epoch.
REQ-002 Parameter FIFO_DEPTH, default 4 (power of 2): ADC sample buffer depth.
REQ-003 Parameter SAMPLE_GAP, default 2: minimum cycles between consecutive new_eeg_data pulses (1 = back-to-back).
REQ-004 Parameter TIMEOUT_CYCLES, default 2^20: inference watchdog limit (used only with REQ-030).
REQ-005 clk  in  1  single clock; all logic is on the rising edge.
REQ-006 soc_ctrl_rst_n  in  1  asynchronous active-low reset.
REQ-007 epoch_req  in  1  one-cycle request to run one sleep epoch.
REQ-008 adc_valid  in  1  adc_data is valid this cycle; no backpressure toward the ADC.
REQ-009 adc_data  in  16  signed EEG sample (AdcData_t).
REQ-010 new_sleep_epoch  out  1  one-cycle epoch-start pulse to CIM.
REQ-011 start_eeg_load  out  1  one-cycle load-start pulse to CIM.
REQ-012 new_eeg_data  out  1  one-cycle pulse; eeg is valid when it is high.
REQ-013 eeg  out  16  sample to CIM (AdcData_t).
REQ-014 inference_complete  in  1  CIM done indication, level or pulse.
REQ-015 busy  out  1  high whenever the state is not IDLE.
REQ-016 epoch_done  out  1  one-cycle pulse when the epoch finishes.
REQ-017 overrun  out  1  sticky flag, set on a FIFO write while full.
REQ-018 timeout  out  1  sticky flag, set on watchdog expiry (tied 0 without REQ-030).

Function
REQ-019 States: IDLE, EPOCH, START, LOAD, WAIT_INF; the state register is one-hot or binary, implementer's choice.
REQ-020 Transitions and pulses:
- IDLE: epoch_req=1 goes to EPOCH; FIFO is flushed; sample counter is cleared to 0.
- EPOCH: new_sleep_epoch=1 for exactly 1 cycle; next state START.
- START: start_eeg_load=1 for exactly 1 cycle; next state LOAD.
REQ-021 FIFO write policy: adc_valid writes to the FIFO only in states START, LOAD and EPOCH; writes in IDLE or WAIT_INF are dropped and do not set overrun.
REQ-022 LOAD issue rule: when the FIFO is non-empty and the gap counter has expired, pop one sample, drive eeg with it and pulse new_eeg_data in the same cycle, and increment the counter.
- The gap counter reloads to SAMPLE_GAP-1 on each pulse.
- eeg holds its last value between pulses.
REQ-023 Minimum FIFO latency: adc_valid at cycle t yields new_eeg_data at t+1, provided the FIFO was empty and the gap counter had expired.
REQ-024 LOAD exit: after the pulse carrying count NUM_SAMPLES-1, go to WAIT_INF; exactly NUM_SAMPLES pulses occur per epoch.
REQ-025 Simultaneous FIFO read and write: a read and write in the same cycle are both honoured.
- When full and a read occurs in that cycle, the write succeeds with no overrun.
- When full with no read, the sample is dropped and overrun is set.
REQ-026 WAIT_INF exit: inference_complete=1 goes to IDLE with epoch_done=1 in that transition cycle.
- inference_complete seen in any other state is ignored.
REQ-027 epoch_req while busy is ignored; requests are not queued.
REQ-028 overrun and timeout clear only on reset or on an accepted epoch_req.

Reset
REQ-029 soc_ctrl_rst_n=0 asynchronously forces the following, regardless of state, including mid-LOAD:
- State to IDLE and FIFO empty.
- Counters to 0.
- All outputs to 0, with eeg=16'h0000.
Release is synchronous: the first active edge is the one after deassertion.

Configuration
REQ-030 Macro SOC_CTRL_WATCHDOG_EN:
- Defined: a counter runs in WAIT_INF. At TIMEOUT_CYCLES without inference_complete, it sets timeout and goes to IDLE with epoch_done=1.
- Undefined: no counter exists, timeout is tied 0, and WAIT_INF waits indefinitely.

Verification
REQ-031 NUM_SAMPLES=4, SAMPLE_GAP=1, adc_valid continuous from START: epoch_req at cycle 0 -> new_sleep_epoch at 1, start_eeg_load at 2, and 4 back-to-back new_eeg_data pulses with eeg equal to the input sequence in order; then inference_complete -> epoch_done, busy=0.
REQ-032 FIFO_DEPTH=4, SAMPLE_GAP=8, 6 consecutive adc_valid -> overrun=1 and the extra samples are dropped; the next epoch_req clears overrun.
REQ-033 soc_ctrl_rst_n pulsed low after 2 of 4 samples -> all outputs 0 immediately; a later epoch_req restarts cleanly with exactly 4 pulses.
REQ-034 epoch_req during LOAD and inference_complete during LOAD -> no effect; the pulse count stays exactly NUM_SAMPLES.
REQ-035 With SOC_CTRL_WATCHDOG_EN, TIMEOUT_CYCLES=16 and no inference_complete -> timeout=1 and epoch_done after 16 WAIT_INF cycles; without the macro, busy stays 1.
